// File: rtl/rp_8bit_arb_pkg.sv
// Shared types for the two-master data-bus arbiter: FSM states, bus owner and lock counter width.
package rp_8bit_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFR  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    localparam int LCW = 4;

endpackage

// File: rtl/rp_8bit_bd_arb.sv
// Round-robin arbiter of CPU (m0) and DMA/debug (m1) onto one slave, with bounded m1 bus locking.
// Latency: request sampled in IDLE drives s_req next cycle; masters stall until their ack, slave may stall indefinitely.
module rp_8bit_bd_arb
    import rp_8bit_arb_pkg::*;
#(
    parameter int DAW = 13,
    parameter int DW  = 8,
    parameter int LCK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m0_req,
    input  logic           m0_wen,
    input  logic [DAW-1:0] m0_adr,
    input  logic [DW-1:0]  m0_wdt,
    output logic [DW-1:0]  m0_rdt,
    output logic           m0_ack,
    input  logic           m1_req,
    input  logic           m1_wen,
    input  logic [DAW-1:0] m1_adr,
    input  logic [DW-1:0]  m1_wdt,
    output logic [DW-1:0]  m1_rdt,
    output logic           m1_ack,
    input  logic           m1_lck,
    output logic           s_req,
    output logic           s_wen,
    output logic [DAW-1:0] s_adr,
    output logic [DW-1:0]  s_wdt,
    input  logic [DW-1:0]  s_rdt,
    input  logic           s_ack
);

    localparam logic [LCW-1:0] LCK_MAX = LCW'(LCK);

    state_t         state, state_nxt;
    owner_t         owner, last_owner, gnt_owner;
    logic           grant;
    logic           xfr_done;
    logic           lck_keep;
    logic [LCW-1:0] lck_cnt, lck_inc;

    assign s_req    = (state == XFR);
    assign xfr_done = s_req && s_ack;
    assign lck_keep = (owner == M1) && m1_lck;
    assign lck_inc  = lck_cnt + LCW'(1);

    assign m0_ack = xfr_done && (owner == M0);
    assign m1_ack = xfr_done && (owner == M1);
    assign m0_rdt = s_rdt;
    assign m1_rdt = s_rdt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_owner = owner;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    state_nxt = XFR;
                    if (m0_req && m1_req) begin
                        gnt_owner = (last_owner == M0) ? M1 : M0;
                    end else begin
                        gnt_owner = m0_req ? M0 : M1;
                    end
                end
            end
            XFR: begin
                // The lock budget counts the transfer completing now.
                if (s_ack) begin
                    state_nxt = (lck_keep && (lck_inc < LCK_MAX)) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (m1_req) begin
                    grant     = 1'b1;
                    gnt_owner = M1;
                    state_nxt = XFR;
                end else if (!m1_lck) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= M0;
            last_owner <= M1;
            lck_cnt    <= '0;
            s_wen      <= 1'b0;
            s_adr      <= '0;
            s_wdt      <= '0;
        end else begin
            if (grant) begin
                owner <= gnt_owner;
                if (gnt_owner == M1) begin
                    s_wen <= m1_wen;
                    s_adr <= m1_adr;
                    s_wdt <= m1_wdt;
                end else begin
                    s_wen <= m0_wen;
                    s_adr <= m0_adr;
                    s_wdt <= m0_wdt;
                end
            end
            if ((state == IDLE) && grant) begin
                lck_cnt <= '0;
            end else if (xfr_done && lck_keep) begin
                lck_cnt <= lck_inc;
            end
            if (xfr_done) begin
                last_owner <= owner;
            end
        end
    end

endmodule

// File: tb/tb_rp_8bit_bd_arb.sv
// Directed bench for the two-master arbiter; a small slave model acks after a programmable delay.
module tb_rp_8bit_bd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wen, m1_req, m1_wen, m1_lck;
    logic [12:0] m0_adr, m1_adr;
    logic [7:0]  m0_wdt, m1_wdt;
    logic [7:0]  m0_rdt, m1_rdt;
    logic        m0_ack, m1_ack;
    logic        s_req, s_wen;
    logic [12:0] s_adr;
    logic [7:0]  s_wdt;
    logic [7:0]  s_rdt = 8'h00;
    logic        s_ack = 1'b0;

    int          checks   = 0;
    int          failures = 0;
    int          ack_dly  = 1;
    int          scnt     = 0;
    logic [7:0]  slave_rdt = 8'h00;

    rp_8bit_bd_arb #(.DAW(13), .DW(8), .LCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_adr(m0_adr), .m0_wdt(m0_wdt),
        .m0_rdt(m0_rdt), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_adr(m1_adr), .m1_wdt(m1_wdt),
        .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_lck(m1_lck),
        .s_req(s_req), .s_wen(s_wen), .s_adr(s_adr), .s_wdt(s_wdt),
        .s_rdt(s_rdt), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    // Slave: ack in the cycle where s_req has been high for ack_dly earlier cycles.
    always @(posedge clk) begin
        #1;
        if (s_req) begin
            s_ack = (scnt == ack_dly);
            s_rdt = slave_rdt;
            scnt  = scnt + 1;
        end else begin
            s_ack = 1'b0;
            scnt  = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_masters();
        m0_req = 1'b0; m0_wen = 1'b0; m0_adr = '0; m0_wdt = '0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_adr = '0; m1_wdt = '0;
        m1_lck = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_masters();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_masters();
        m0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%0b exp=0", s_req); end
        checks++; if (s_wen !== 1'b0) begin failures++; $display("FAIL reset_s_wen got=%0b exp=0", s_wen); end
        checks++; if (s_adr !== 13'h0000) begin failures++; $display("FAIL reset_s_adr got=%h exp=0000", s_adr); end
        checks++; if (s_wdt !== 8'h00) begin failures++; $display("FAIL reset_s_wdt got=%h exp=00", s_wdt); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {m0_ack, m1_ack}); end
        m0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%0b exp=0", s_req); end
    endtask

    task automatic test_single_read();
        ack_dly = 1; slave_rdt = 8'h5A;
        m0_req = 1'b1; m0_wen = 1'b0; m0_adr = 13'h0010;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_adr !== 13'h0010 || s_wen !== 1'b0) begin
            failures++; $display("FAIL read_c1 got=req%0b adr%h wen%0b exp=req1 adr0010 wen0", s_req, s_adr, s_wen); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL read_c1_acks got=%b exp=00", {m0_ack, m1_ack}); end
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1 || m0_rdt !== 8'h5A) begin
            failures++; $display("FAIL read_c2_ack got=ack%0b rdt%h exp=ack1 rdt5a", m0_ack, m0_rdt); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL read_c2_m1ack got=%0b exp=0", m1_ack); end
        @(negedge clk);
        checks++; if (s_req !== 1'b0 || m0_ack !== 1'b0) begin
            failures++; $display("FAIL read_c3_idle got=req%0b ack%0b exp=req0 ack0", s_req, m0_ack); end
        m0_req = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [12:0] ea;
        do_reset();
        ack_dly = 1;
        m0_req = 1'b1; m0_adr = 13'h0100;
        m1_req = 1'b1; m1_adr = 13'h0200;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ea = ((((c - 1) / 3) % 2) == 0) ? 13'h0100 : 13'h0200;
            checks++; if (s_req !== ((c % 3) != 0)) begin
                failures++; $display("FAIL rr_s_req c%0d got=%0b exp=%0b", c, s_req, ((c % 3) != 0)); end
            if ((c % 3) != 0) begin
                checks++; if (s_adr !== ea) begin failures++; $display("FAIL rr_owner c%0d got=%h exp=%h", c, s_adr, ea); end
            end
            checks++; if (m0_ack !== (c == 2 || c == 8) || m1_ack !== (c == 5 || c == 11)) begin
                failures++; $display("FAIL rr_acks c%0d got=%0b%0b", c, m0_ack, m1_ack); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_lock();
        logic [12:0] exp_adr [7];
        logic        exp_own [7];
        logic [12:0] log_adr [7];
        logic        log_own [7];
        int          n = 0;
        int          k = 0;
        logic        m1_adv = 1'b0;
        logic        m0_drop = 1'b0;
        exp_adr = '{13'h0300, 13'h0301, 13'h0302, 13'h0303, 13'h00AA, 13'h0304, 13'h0305};
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin log_adr[i] = '0; log_own[i] = 1'b0; end
        @(negedge clk);
        ack_dly = 1;
        m1_req = 1'b1; m1_lck = 1'b1; m1_wen = 1'b1; m1_adr = 13'h0300; m1_wdt = 8'h00;
        m0_wen = 1'b1; m0_adr = 13'h00AA; m0_wdt = 8'h77;
        for (int c = 1; c <= 80 && n < 7; c++) begin
            @(negedge clk);
            if (c == 1) m0_req = 1'b1;
            if (m1_adv) begin
                k++;
                m1_adr = 13'h0300 + 13'(k);
                m1_wdt = 8'(k);
                m1_lck = (k < 5);
                m1_adv = 1'b0;
            end
            if (m0_drop) begin m0_req = 1'b0; m0_drop = 1'b0; end
            if (m1_ack) begin log_adr[n] = s_adr; log_own[n] = 1'b1; n++; m1_adv = 1'b1; end
            else if (m0_ack) begin log_adr[n] = s_adr; log_own[n] = 1'b0; n++; m0_drop = 1'b1; end
        end
        @(negedge clk);
        m1_req = 1'b0; m1_lck = 1'b0;
        checks++; if (n != 7) begin failures++; $display("FAIL lock_count got=%0d exp=7", n); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (log_own[i] !== exp_own[i] || log_adr[i] !== exp_adr[i]) begin
                failures++; $display("FAIL lock_seq%0d got=m%0b/%h exp=m%0b/%h", i, log_own[i], log_adr[i], exp_own[i], exp_adr[i]); end
        end
    endtask

    task automatic test_lck_ignored();
        @(negedge clk);
        ack_dly = 1; m1_lck = 1'b1;
        m0_req = 1'b1; m0_wen = 1'b0; m0_adr = 13'h0050;
        @(negedge clk);
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL lckign_ack1 got=%0b exp=1", m0_ack); end
        @(negedge clk);
        m0_adr = 13'h0051;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_adr !== 13'h0051) begin
            failures++; $display("FAIL lckign_regrant got=req%0b adr%h exp=req1 adr0051", s_req, s_adr); end
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL lckign_ack2 got=%0b exp=1", m0_ack); end
        @(negedge clk);
        m0_req = 1'b0; m1_lck = 1'b0;
    endtask

    task automatic test_capture();
        @(negedge clk);
        ack_dly = 3;
        m0_req = 1'b1; m0_wen = 1'b1; m0_adr = 13'h1FFF; m0_wdt = 8'hA5;
        @(negedge clk);
        checks++; if (s_adr !== 13'h1FFF || s_wdt !== 8'hA5 || s_wen !== 1'b1) begin
            failures++; $display("FAIL cap_c1 got=adr%h wdt%h wen%0b exp=adr1fff wdta5 wen1", s_adr, s_wdt, s_wen); end
        m0_adr = 13'h0000; m0_wdt = 8'h00; m0_wen = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (s_req !== 1'b1 || s_adr !== 13'h1FFF || s_wdt !== 8'hA5 || s_wen !== 1'b1) begin
                failures++; $display("FAIL cap_hold c%0d got=req%0b adr%h wdt%h wen%0b", c, s_req, s_adr, s_wdt, s_wen); end
            checks++; if (m0_ack !== (c == 4)) begin failures++; $display("FAIL cap_ack c%0d got=%0b exp=%0b", c, m0_ack, (c == 4)); end
        end
        @(negedge clk);
        m0_req = 1'b0;
    endtask

    task automatic test_long_ack();
        int cyc;
        @(negedge clk);
        ack_dly = 5; slave_rdt = 8'h3C;
        m0_req = 1'b1; m0_wen = 1'b0; m0_adr = 13'h0456;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++; if (s_req !== 1'b1 || s_adr !== 13'h0456) begin
                failures++; $display("FAIL long_sreq c%0d got=req%0b adr%h exp=req1 adr0456", c, s_req, s_adr); end
            checks++; if (m0_ack !== (c == 6) || m1_ack !== 1'b0) begin
                failures++; $display("FAIL long_acks c%0d got=%0b%0b exp=%0b0", c, m0_ack, m1_ack, (c == 6)); end
            if (c == 1) begin m1_req = 1'b1; m1_wen = 1'b0; m1_adr = 13'h0123; m1_lck = 1'b0; end
            if (c == 6) begin
                checks++; if (m0_rdt !== 8'h3C) begin failures++; $display("FAIL long_rdt got=%h exp=3c", m0_rdt); end
            end
        end
        @(negedge clk);
        checks++; if (s_req !== 1'b0 || m0_ack !== 1'b0) begin
            failures++; $display("FAIL long_c7 got=req%0b ack%0b exp=req0 ack0", s_req, m0_ack); end
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_adr !== 13'h0123) begin
            failures++; $display("FAIL long_m1grant got=req%0b adr%h exp=req1 adr0123", s_req, s_adr); end
        cyc = 8;
        while (m1_ack !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 13) begin failures++; $display("FAIL long_m1ack_cycle got=%0d exp=13", cyc); end
        @(negedge clk);
        m1_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ack_dly = 3;
        m0_req = 1'b1; m0_wen = 1'b1; m0_adr = 13'h0777; m0_wdt = 8'h11;
        m1_req = 1'b1; m1_wen = 1'b1; m1_adr = 13'h0888; m1_wdt = 8'h22;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_adr !== 13'h0777) begin
            failures++; $display("FAIL rstmid_c1 got=req%0b adr%h exp=req1 adr0777", s_req, s_adr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (s_req !== 1'b0 || s_adr !== 13'h0000) begin
            failures++; $display("FAIL rstmid_async got=req%0b adr%h exp=req0 adr0000", s_req, s_adr); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_acks got=%b exp=00", {m0_ack, m1_ack}); end
        @(negedge clk);
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL rstmid_held got=%0b exp=0", s_req); end
        rst = 1'b1; m1_req = 1'b0; ack_dly = 1;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_adr !== 13'h0777 || m0_ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_r1 got=req%0b adr%h ack%0b exp=req1 adr0777 ack0", s_req, s_adr, m0_ack); end
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_r2 got=%0b%0b exp=10", m0_ack, m1_ack); end
        @(negedge clk);
        m0_req = 1'b0;
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL rstmid_r3 got=%0b exp=0", s_req); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_lck_ignored();
        test_capture();
        test_long_ack();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
